light_conflict_monitor: RTL

Safety stage directly downstream of the two-way traffic-light controller. It samples the controller's LightA/LightB lamp codes every cycle, checks encoding, mutual exclusion, sequence order, minimum yellow time and maximum dwell, and forwards the codes to the lamp drivers one cycle later. On the first violation it latches a fault code and forces both approaches to flashing red until reset.

---
 rtl/light_conflict_monitor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/light_conflict_monitor.sv
// Safety stage between the two-way light controller and the lamp drivers.
// Checks every sample, forwards healthy codes one cycle later, and on the first violation latches a fault and flashes red.
module light_conflict_monitor #(
  parameter int YELLOW_MIN = 3,
  parameter int MAX_DWELL  = 15,
  parameter int BLINK_HALF = 2,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] LightA,
  input  logic [2:0] LightB,
  output logic [2:0] DriveA,
  output logic [2:0] DriveB,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] LAMP_DARK   = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [2:0] {
    FC_NONE         = 3'b000,
    FC_ENCODING     = 3'b001,
    FC_CONFLICT     = 3'b010,
    FC_SEQUENCE     = 3'b011,
    FC_SHORT_YELLOW = 3'b100,
    FC_TIMEOUT      = 3'b101
  } fault_code_t;

  typedef enum logic {
    MODE_HEALTHY = 1'b0,
    MODE_FAULT   = 1'b1
  } mode_t;

  mode_t            mode;
  logic [2:0]       prev_a;
  logic [2:0]       prev_b;
  logic             primed;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] blink;
  fault_code_t      check_code;
  logic [CNT_W-1:0] dwell_next;

  function automatic logic is_lamp(input logic [2:0] v);
    return (v == LAMP_GREEN) || (v == LAMP_YELLOW) || (v == LAMP_RED);
  endfunction

  function automatic logic legal_change(input logic [2:0] p, input logic [2:0] c);
    return (p == c) ||
           (p == LAMP_GREEN  && c == LAMP_YELLOW) ||
           (p == LAMP_YELLOW && c == LAMP_RED) ||
           (p == LAMP_RED    && c == LAMP_GREEN);
  endfunction

  // Highest-priority failing check on the current sample; sequence-based checks need a valid prev.
  always_comb begin
    logic same;
    logic leaving_yellow;
    same           = (LightA == prev_a) && (LightB == prev_b);
    leaving_yellow = (prev_a == LAMP_YELLOW && LightA != LAMP_YELLOW) ||
                     (prev_b == LAMP_YELLOW && LightB != LAMP_YELLOW);
    check_code = FC_NONE;
    if (!is_lamp(LightA) || !is_lamp(LightB))
      check_code = FC_ENCODING;
    else if (LightA != LAMP_RED && LightB != LAMP_RED)
      check_code = FC_CONFLICT;
    else if (primed && (!legal_change(prev_a, LightA) || !legal_change(prev_b, LightB)))
      check_code = FC_SEQUENCE;
    else if (primed && leaving_yellow && dwell < CNT_W'(YELLOW_MIN))
      check_code = FC_SHORT_YELLOW;
    else if (primed && same && dwell == CNT_W'(MAX_DWELL))
      check_code = FC_TIMEOUT;

    if (!primed || !same)
      dwell_next = CNT_W'(1);
    else if (dwell == CNT_W'(MAX_DWELL + 1))
      dwell_next = dwell;
    else
      dwell_next = dwell + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode       <= MODE_HEALTHY;
      fault_code <= FC_NONE;
      DriveA     <= LAMP_RED;
      DriveB     <= LAMP_RED;
      prev_a     <= LAMP_RED;
      prev_b     <= LAMP_RED;
      primed     <= 1'b0;
      dwell      <= '0;
      blink      <= '0;
    end else begin
      case (mode)
        MODE_HEALTHY: begin
          primed <= 1'b1;
          if (check_code != FC_NONE) begin
            mode       <= MODE_FAULT;
            fault_code <= check_code;
            DriveA     <= LAMP_RED;
            DriveB     <= LAMP_RED;
            blink      <= '0;
          end else begin
            DriveA <= LightA;
            DriveB <= LightB;
            prev_a <= LightA;
            prev_b <= LightB;
            dwell  <= dwell_next;
          end
        end
        MODE_FAULT: begin
          // Both approaches flash red in lockstep until reset.
          if (blink == CNT_W'(BLINK_HALF - 1)) begin
            blink  <= '0;
            DriveA <= (DriveA == LAMP_RED) ? LAMP_DARK : LAMP_RED;
            DriveB <= (DriveB == LAMP_RED) ? LAMP_DARK : LAMP_RED;
          end else begin
            blink <= blink + CNT_W'(1);
          end
        end
        default: mode <= MODE_FAULT;
      endcase
    end
  end

  assign fault = (mode == MODE_FAULT);

endmodule
